// File: rtl/parallax_starfield.sv
// Multi-layer parallax starfield: per-layer Galois LFSR stars, scrolled
// during vertical blanking. Ports: clk, reset, hpos/vpos/display_on in; speed, freeze in; rgb, busy out.
module parallax_starfield #(
  parameter int NUM_LAYERS = 3,
  parameter int LFSR_W = 19,
  parameter logic [LFSR_W-1:0] TAPS = 19'b1110010000000000000,
  parameter logic [LFSR_W-1:0] SEED_BASE = '1,
  parameter int FIELD_W = 640,
  parameter int FIELD_H = 480,
  parameter int DENSITY_BITS = 9,
  parameter int SPEED_W = 4,
  parameter int POS_W = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [POS_W-1:0]              hpos,
  input  logic [POS_W-1:0]              vpos,
  input  logic                          display_on,
  input  logic [NUM_LAYERS*SPEED_W-1:0] speed,
  input  logic                          freeze,
  output logic [2:0]                    rgb,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADVANCE,
    LOAD
  } state_t;

  localparam logic [POS_W-1:0] FW = POS_W'(FIELD_W);
  localparam logic [POS_W-1:0] FH = POS_W'(FIELD_H);
  localparam logic [POS_W-1:0] XL = POS_W'(FIELD_W - 1);
  localparam logic [POS_W-1:0] YL = POS_W'(FIELD_H - 1);

  function automatic logic [LFSR_W-1:0] step(
    input logic [LFSR_W-1:0] s
  );
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? TAPS : '0);
  endfunction

  logic in_field;
  logic frame_end;

  assign in_field  = (hpos < FW) && (vpos < FH);
  assign frame_end = in_field && (hpos == XL) && (vpos == YL);

  logic [NUM_LAYERS-1:0]   star;
  logic [NUM_LAYERS-1:0]   act;
  logic [NUM_LAYERS*3-1:0] col;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    localparam logic [LFSR_W-1:0] SEED =
      SEED_BASE ^ (LFSR_W'(k) << 4);

    state_t              state_q;
    state_t              state_d;
    logic [LFSR_W-1:0]   lfsr;
    logic [LFSR_W-1:0]   start;
    logic [SPEED_W-1:0]  rem;
    logic [SPEED_W-1:0]  spd;

    assign spd = freeze ? '0 : speed[k*SPEED_W +: SPEED_W];

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:
          if (frame_end)
            state_d = (spd != '0) ? ADVANCE : LOAD;
        ADVANCE:
          if (rem == SPEED_W'(1))
            state_d = LOAD;
        LOAD:
          state_d = IDLE;
        default:
          state_d = IDLE;
      endcase
    end

    // lfsr only free-runs in IDLE; a too-short blanking
    // just stalls it until the sequence completes.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        lfsr    <= SEED;
        start   <= SEED;
        rem     <= '0;
      end else begin
        state_q <= state_d;
        unique case (state_q)
          IDLE:
            if (frame_end)
              rem <= spd;
            else if (in_field)
              lfsr <= step(lfsr);
          ADVANCE: begin
            start <= step(start);
            rem   <= rem - SPEED_W'(1);
          end
          LOAD:
            lfsr <= start;
          default: ;
        endcase
      end
    end

    assign star[k] = &lfsr[LFSR_W-1 -: DENSITY_BITS];
    assign act[k]  = (state_q != IDLE);
    assign col[k*3 +: 3] = (k == 0) ? 3'b111 : lfsr[2:0];
  end

  logic [2:0] sel;

  // Walk from the farthest layer so the nearest star wins.
  always_comb begin
    sel = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--)
      if (star[k])
        sel = col[k*3 +: 3];
  end

  // Seeds may themselves be stars, so reset must blank rgb
  // directly rather than rely on the layer state.
  assign rgb = (!reset && display_on && in_field && (|star))
             ? sel : 3'b000;
  assign busy = |act;

endmodule

// File: tb/tb_parallax_starfield.sv
// Directed bench for parallax_starfield on a 16x8 field, 2 layers.
// Raster 20x10 driven by the bench, reference LFSR model for rgb.
module tb_parallax_starfield;

  localparam int HT = 20;
  localparam int VT = 10;
  localparam int FW = 16;
  localparam int FH = 8;
  localparam logic [18:0] TAPS  = 19'b1110010000000000000;
  localparam logic [18:0] SEED0 = 19'h7FFFF;
  localparam logic [18:0] SEED1 = 19'h7FFEF;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic [7:0] speed;
  logic       freeze;
  logic [2:0] rgb;
  logic       busy;

  always #5 clk = ~clk;

  parallax_starfield #(
    .NUM_LAYERS(2),
    .FIELD_W(FW),
    .FIELD_H(FH),
    .DENSITY_BITS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hpos(hpos),
    .vpos(vpos),
    .display_on(display_on),
    .speed(speed),
    .freeze(freeze),
    .rgb(rgb),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit de_en;
  int bcnt;
  int busy_exp;
  logic [18:0] m_lfsr [2];
  logic [18:0] m_start [2];
  logic [2:0] obs_cur [FH][FW];
  logic [2:0] exp_cur [FH][FW];
  logic [2:0] exp_prev [FH][FW];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] step(input logic [18:0] s);
    return {1'b0, s[18:1]} ^ (s[0] ? TAPS : 19'd0);
  endfunction

  function automatic logic [2:0] exp_rgb();
    if (!de_en) return 3'b000;
    if (&m_lfsr[0][18:16]) return 3'b111;
    if (&m_lfsr[1][18:16]) return m_lfsr[1][2:0];
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_lfsr[0] = SEED0;
    m_start[0] = SEED0;
    m_lfsr[1] = SEED1;
    m_start[1] = SEED1;
  endtask

  task automatic pix(input int h, input int v);
    bit inf;
    bit fe;
    int e;
    @(negedge clk);
    hpos = 10'(h);
    vpos = 10'(v);
    inf = (h < FW) && (v < FH);
    display_on = inf && de_en;
    #1;
    if (h == 0 && v == 0) begin
      chk("lfsr0@origin", 32'(dut.g_layer[0].lfsr), 32'(m_lfsr[0]));
      chk("lfsr1@origin", 32'(dut.g_layer[1].lfsr), 32'(m_lfsr[1]));
      chk("start0@origin", 32'(dut.g_layer[0].start), 32'(m_start[0]));
      chk("start1@origin", 32'(dut.g_layer[1].start), 32'(m_start[1]));
    end
    if (inf) begin
      exp_cur[v][h] = exp_rgb();
      obs_cur[v][h] = rgb;
      chk($sformatf("rgb(%0d,%0d)", h, v), 32'(rgb), 32'(exp_cur[v][h]));
    end else if (busy) begin
      bcnt++;
    end
    fe = inf && (h == FW - 1) && (v == FH - 1);
    if (fe) begin
      busy_exp = 1;
      for (int k = 0; k < 2; k++) begin
        e = freeze ? 0 : int'(speed[k*4 +: 4]);
        repeat (e) m_start[k] = step(m_start[k]);
        m_lfsr[k] = m_start[k];
        if (e + 1 > busy_exp) busy_exp = e + 1;
      end
    end else if (inf) begin
      for (int k = 0; k < 2; k++) m_lfsr[k] = step(m_lfsr[k]);
    end
  endtask

  // mode 0: no trace check, 1: same as last frame, 2: shifted left 1
  task automatic frame(input int mode, input bit chg,
                       input logic [7:0] nspd, input bit abort);
    int bad;
    bcnt = 0;
    busy_exp = 0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (abort && v == FH - 1 && h == FW + 2) return;
        if (chg && v == 3 && h == 5) speed = nspd;
        pix(h, v);
      end
    end
    chk("busy_len", 32'(bcnt), 32'(busy_exp));
    if (mode != 0) begin
      bad = 0;
      for (int y = 0; y < FH; y++)
        for (int x = 0; x < FW; x++)
          if (mode == 1) begin
            if (obs_cur[y][x] !== exp_prev[y][x]) bad++;
          end else if (x < FW - 1) begin
            if (obs_cur[y][x] !== exp_prev[y][x+1]) bad++;
          end
      chk(mode == 1 ? "static_trace" : "shift_trace", 32'(bad), 32'd0);
    end
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++)
        exp_prev[y][x] = exp_cur[y][x];
  endtask

  initial begin
    reset = 1'b1;
    hpos = '0;
    vpos = '0;
    display_on = 1'b1;
    speed = '0;
    freeze = 1'b0;
    de_en = 1'b1;
    model_reset();
    #1;
    chk("rgb_in_reset", 32'(rgb), 32'd0);
    chk("busy_in_reset", 32'(busy), 32'd0);
    hpos = 10'(HT - 1);
    vpos = 10'(VT - 1);
    display_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    hpos = '0;
    vpos = '0;
    display_on = 1'b1;
    #1;
    chk("l0_wins", 32'(rgb), 32'h7);
    display_on = 1'b0;
    #1;
    chk("de_off", 32'(rgb), 32'd0);
    hpos = 10'(HT - 1);
    vpos = 10'(VT - 1);

    frame(0, 1'b0, 8'h00, 1'b0);
    frame(1, 1'b0, 8'h00, 1'b0);
    frame(1, 1'b0, 8'h00, 1'b0);

    speed = 8'h11;
    frame(1, 1'b0, 8'h00, 1'b0);
    frame(2, 1'b0, 8'h00, 1'b0);
    frame(2, 1'b0, 8'h00, 1'b0);

    speed = 8'h0F;
    frame(2, 1'b0, 8'h00, 1'b0);
    speed = 8'h00;
    frame(0, 1'b0, 8'h00, 1'b0);

    frame(1, 1'b1, 8'h22, 1'b0);
    freeze = 1'b1;
    frame(0, 1'b0, 8'h00, 1'b0);
    freeze = 1'b0;
    frame(1, 1'b0, 8'h00, 1'b0);
    de_en = 1'b0;
    frame(0, 1'b0, 8'h00, 1'b0);
    de_en = 1'b1;

    speed = 8'h0F;
    frame(0, 1'b0, 8'h00, 1'b1);
    chk("busy_mid_adv", 32'(busy), 32'd1);
    hpos = '0;
    vpos = '0;
    display_on = 1'b1;
    reset = 1'b1;
    #1;
    chk("rgb_async_rst", 32'(rgb), 32'd0);
    chk("busy_async_rst", 32'(busy), 32'd0);
    chk("lfsr0_rst", 32'(dut.g_layer[0].lfsr), 32'(SEED0));
    chk("start0_rst", 32'(dut.g_layer[0].start), 32'(SEED0));
    chk("lfsr1_rst", 32'(dut.g_layer[1].lfsr), 32'(SEED1));
    chk("start1_rst", 32'(dut.g_layer[1].start), 32'(SEED1));
    hpos = 10'(HT - 1);
    vpos = 10'(VT - 1);
    display_on = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    speed = 8'h00;
    frame(0, 1'b0, 8'h00, 1'b0);
    frame(1, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parallax_starfield.md
Name: parallax_starfield

Overview:
Multi-layer scrolling starfield generator for the VGA pixel pipeline. It sits beside the sync generator and consumes that generator's pixel coordinates and active-video flag. Each of NUM_LAYERS layers owns a Galois LFSR that steps once per in-field pixel; a star is drawn where the LFSR's top bits are all ones. Per-layer horizontal scroll speed is programmable at run time: during vertical blanking, each layer's frame-start state is advanced by speed_k LFSR steps, which shifts that layer left by speed_k pixels per frame and produces parallax.

Parameters:
NUM_LAYERS, 3, number of star layers; layer 0 is nearest and has highest priority.
LFSR_W, 19, LFSR width in bits.
TAPS, 19'b1110010000000000000, Galois tap mask, LFSR_W bits wide; must be maximal-length.
SEED_BASE, all ones (LFSR_W bits), base seed; seed_k = SEED_BASE ^ (k << 4); every seed_k must be nonzero.
FIELD_W, 640, star field width in pixels.
FIELD_H, 480, star field height in pixels.
DENSITY_BITS, 9, number of top LFSR bits that must all be 1 to draw a star.
SPEED_W, 4, width of each per-layer speed field.
POS_W, 10, width of hpos and vpos.

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
hpos  in  POS_W  current pixel x from the sync generator
vpos  in  POS_W  current pixel y from the sync generator
display_on  in  1  active-video flag from the sync generator
speed  in  NUM_LAYERS*SPEED_W  packed per-layer speed in pixels/frame; layer k occupies bits [k*SPEED_W +: SPEED_W]
freeze  in  1  when high, all speeds are treated as 0
rgb  out  3  pixel colour
busy  out  1  high while any layer is outside IDLE

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high. While reset is asserted:
  - lfsr_k = start_k = seed_k;
  - every layer FSM is in IDLE;
  - rgb = 0 and busy = 0, with no clock required.
- LFSR step function: next = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? TAPS : 0).
- Field enable: in_field = (hpos < FIELD_W) & (vpos < FIELD_H).
- frame_end = in_field & (hpos == FIELD_W-1) & (vpos == FIELD_H-1).
- Per-layer FSM, one per layer, states IDLE / ADVANCE / LOAD:
  - IDLE:
    - If in_field & !frame_end: lfsr_k steps once.
    - If frame_end: rem_k <= (freeze ? 0 : speed_k), lfsr_k holds, and the FSM goes to ADVANCE if that value is nonzero, otherwise to LOAD.
  - ADVANCE: each clock, start_k steps once and rem_k decrements. When rem_k == 1, the FSM goes to LOAD. lfsr_k does not step.
  - LOAD: lfsr_k <= start_k (the already-advanced value); the FSM goes to IDLE. Takes 1 clock.
- Frame-end sequence length: speed_k + 1 clocks after frame_end. Worst case 2^SPEED_W clocks, well inside vertical blanking.
- If in_field rises while a layer is not IDLE (illegal, too-short blanking): that layer's lfsr_k does not step and its FSM completes normally.
- speed and freeze are sampled only at frame_end. Changes mid-frame take effect at the next frame.
- A speed of 0 yields a static field: every frame starts from the same start_k.
- Star detect: star_k = &lfsr_k[LFSR_W-1 -: DENSITY_BITS].
- Colour, combinational, zero latency relative to hpos/vpos:
  - Select the lowest k with star_k.
  - Layer 0 colour = 3'b111. Layer k>0 colour = lfsr_k[2:0]; a value of 0 renders black.
  - rgb = display_on & in_field & (any star_k) ? selected colour : 3'b000.
- busy = OR of (FSM_k != IDLE).
- Width rules: rem_k is SPEED_W bits. No arithmetic wraps beyond the decrement, which stops at 1.

Test Plan:
1. NUM_LAYERS=1, FIELD_W=16, FIELD_H=8, speed=0; reset, run 3 frames -> lfsr_0 == seed_0 at (0,0) of every frame; rgb trace identical frame to frame.
2. speed_0=1 -> frame n+1 rgb at (x,y) == frame n rgb at (x+1,y) for all x<15 in the 16x8 field; start_0 differs from the prior frame's value by exactly one step.
3. speed_0=15 -> busy high for exactly 16 clocks after frame_end (15 ADVANCE + 1 LOAD); lfsr_0 at the next (0,0) equals seed_0 stepped 15 times per the bench model.
4. Force seed_0 and seed_1 with top 9 bits all ones at the same pixel -> rgb=3'b111 (layer 0 wins); seed_0 without a star and seed_1 with lfsr[2:0]=3'b101 -> rgb=3'b101; display_on=0 -> rgb=0.
5. Assert reset mid-ADVANCE with no clock edge -> rgb=0 and busy=0 immediately; after release, lfsr_k=start_k=seed_k and the FSM is in IDLE.
6. Change speed from 0 to 2 at mid-frame pixel (5,3) -> the current frame_end still uses 0 (busy high for 1 clock); the next frame_end uses 2 (busy high for 3 clocks); freeze=1 at frame_end -> busy high for 1 clock.
